// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select lines of a shared 4:1 mux.
// A grant is held for at most MAX_HOLD cycles; handoff between requesters takes a single edge.
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       s0,
  output logic       s1,
  output logic       busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

  logic [0:0] state;
  logic [1:0] owner;
  logic [1:0] ptr;
  logic [3:0] hold_cnt;

  logic       win_vld;
  logic [1:0] win;
  logic [1:0] idx;
  logic       keep;

  // Scan from ptr upward; the reversed loop lets the nearest candidate overwrite the rest.
  always_comb begin
    win_vld = 1'b0;
    win     = ptr;
    idx     = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
  end

  assign keep = req[owner] && (hold_cnt < HOLD_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 2'd0;
      ptr      <= 2'd0;
      hold_cnt <= 4'd0;
      gnt      <= 4'b0000;
      s0       <= 1'b0;
      s1       <= 1'b0;
      busy     <= 1'b0;
    end else if (state == GRANT && keep) begin
      hold_cnt <= hold_cnt + 4'd1;
    end else if (win_vld) begin
      // Covers both a fresh grant from IDLE and an immediate handoff on release.
      state    <= GRANT;
      owner    <= win;
      ptr      <= win + 2'd1;
      hold_cnt <= 4'd1;
      gnt      <= 4'b0001 << win;
      s0       <= win[1];
      s1       <= win[0];
      busy     <= 1'b1;
    end else begin
      // Nothing pending: drop to IDLE, selects keep their last value.
      state    <= IDLE;
      gnt      <= 4'b0000;
      busy     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: stimulus pushes hand-computed expectations tagged by cycle,
// a monitor pops and compares them after each edge, including the output of a behavioural 4:1 mux.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b1111;
  logic [3:0] gnt;
  logic       s0, s1, busy;
  logic [3:0] data = 4'b0000;
  logic       mux_out;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    int         mux;
    string      nm;
  } exp_t;

  exp_t q[$];

  mux_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt),
    .s0  (s0),
    .s1  (s1),
    .busy(busy)
  );

  // mux_4to1 stand-in: index {s0,s1} selects a/b/c/d = data[0..3]
  assign mux_out = data[{s0, s1}];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    exp_t e;
    #2;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc || gnt !== e.gnt || {s0, s1} !== e.sel || busy !== e.busy ||
          (e.mux >= 0 && mux_out !== e.mux[0])) begin
        errors++;
        $display("FAIL %s cyc=%0d: got gnt=%b sel=%b busy=%b mux=%b, want gnt=%b sel=%b busy=%b mux=%0d (due cyc %0d)",
                 e.nm, cyc, gnt, {s0, s1}, busy, mux_out, e.gnt, e.sel, e.busy, e.mux, e.cyc);
      end
    end
  end

  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] eg,
                      input logic [1:0] es, input logic eb, input int em, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    e.cyc  = cyc + 1;
    e.gnt  = eg;
    e.sel  = es;
    e.busy = eb;
    e.mux  = em;
    e.nm   = nm;
    q.push_back(e);
  endtask

  // Continuous 1111 from a fresh reset: 4-cycle windows 0,1,2,3 then back to 0.
  task automatic all_req(input string nm, input logic use_mux);
    logic [3:0] m;
    m = 4'b0101;
    for (int k = 0; k < 17; k++) begin
      int i;
      i = (k / 4) % 4;
      step(1'b0, 4'b1111, 4'b0001 << i, 2'(i), 1'b1, use_mux ? int'(m[i]) : -1, nm);
    end
  endtask

  initial begin
    // 1. reset then all request
    step(1'b1, 4'b1111, 4'b0000, 2'b00, 1'b0, -1, "reset_a");
    step(1'b1, 4'b1111, 4'b0000, 2'b00, 1'b0, -1, "reset_b");
    all_req("rr_all", 1'b0);

    // 2. lone requester, continuous re-grant past the hold limit
    step(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, -1, "reset_t2");
    for (int k = 0; k < 20; k++)
      step(1'b0, 4'b0100, 4'b0100, 2'b10, 1'b1, -1, "lone");

    // 3. early drop: idle keeps select, 3-cycle grant, then idle
    step(1'b0, 4'b0000, 4'b0000, 2'b10, 1'b0, -1, "idle_keep_sel");
    for (int k = 0; k < 3; k++)
      step(1'b0, 4'b0001, 4'b0001, 2'b00, 1'b1, -1, "early_grant");
    step(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, -1, "early_drop");

    // 4. handoff without bubble
    step(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, -1, "reset_t4");
    step(1'b0, 4'b0011, 4'b0001, 2'b00, 1'b1, -1, "ho_first");
    step(1'b0, 4'b0011, 4'b0001, 2'b00, 1'b1, -1, "ho_second");
    step(1'b0, 4'b0010, 4'b0010, 2'b01, 1'b1, -1, "ho_switch");
    step(1'b0, 4'b0010, 4'b0010, 2'b01, 1'b1, -1, "ho_hold");
    step(1'b0, 4'b0000, 4'b0000, 2'b01, 1'b0, -1, "ho_release");

    // 5. reset mid-grant overrides req
    step(1'b0, 4'b0100, 4'b0100, 2'b10, 1'b1, -1, "pre_rst");
    step(1'b0, 4'b0100, 4'b0100, 2'b10, 1'b1, -1, "pre_rst");
    step(1'b1, 4'b1100, 4'b0000, 2'b00, 1'b0, -1, "mid_rst");
    for (int k = 0; k < 4; k++)
      step(1'b0, 4'b1100, 4'b0100, 2'b10, 1'b1, -1, "post_rst_c");
    for (int k = 0; k < 4; k++)
      step(1'b0, 4'b1100, 4'b1000, 2'b11, 1'b1, -1, "post_rst_d");
    step(1'b0, 4'b1100, 4'b0100, 2'b10, 1'b1, -1, "post_rst_wrap");
    step(1'b0, 4'b0000, 4'b0000, 2'b10, 1'b0, -1, "post_rst_idle");

    // 6. integrated with the mux: a=1 b=0 c=1 d=0
    data = 4'b0101;
    step(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1, "reset_t6");
    all_req("mux_out", 1'b1);

    repeat (3) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

endmodule
